fpga_vga_timing: RTL

FPGA_VGA_TIMING -- requirements
Module: fpga_vga_timing

---
 rtl/fpga_vga_timing.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fpga_vga_timing.sv
// -----------------------------------------------------------------------------
// fpga_vga_timing
// Free-running VGA raster timing generator. Horizontal and vertical position
// counters step on every cycle with en=1. The sync, display-enable, pixel
// coordinate and start-pulse outputs are decoded from those counters and
// registered.
//
// Ports:
//   fpga_CLK_AUX  in   pixel clock; all logic runs on its rising edge
//   fpga_NRST     in   asynchronous active-low reset
//   en            in   timing enable (level); while 0, counters and outputs hold
//   vga_hs        out  horizontal sync, active-low
//   vga_vs        out  vertical sync, active-low
//   vga_de        out  display enable, high inside the active area
//   pix_x [10:0]  out  active-area column, 0 outside the active area
//   pix_y [9:0]   out  active-area row, 0 outside the active area
//   frame_start   out  one-cycle pulse at pixel (0,0)
//   line_start    out  one-cycle pulse at column 0 of every active line
//
// Parameters must satisfy HTOT <= 2048 and VTOT <= 1024.
// -----------------------------------------------------------------------------
module fpga_vga_timing #(
  parameter int unsigned HDISP  = 640,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 16,
  parameter int unsigned HPULSE = 96,
  parameter int unsigned HBP    = 48,
  parameter int unsigned VFP    = 11,
  parameter int unsigned VPULSE = 2,
  parameter int unsigned VBP    = 31
) (
  input  logic        fpga_CLK_AUX,
  input  logic        fpga_NRST,
  input  logic        en,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOT = VDISP + VFP + VPULSE + VBP;

  localparam logic [10:0] H_LAST = 11'(HTOT - 1);
  localparam logic [9:0]  V_LAST = 10'(VTOT - 1);

  // Boundaries are one bit wider than the counters, so a sync region that
  // ends exactly at HTOT=2048 / VTOT=1024 does not wrap to zero.
  localparam logic [11:0] H_DISP_E  = 12'(HDISP);
  localparam logic [11:0] H_SYNC_B  = 12'(HDISP + HFP);
  localparam logic [11:0] H_SYNC_E  = 12'(HDISP + HFP + HPULSE);
  localparam logic [10:0] V_DISP_E  = 11'(VDISP);
  localparam logic [10:0] V_SYNC_B  = 11'(VDISP + VFP);
  localparam logic [10:0] V_SYNC_E  = 11'(VDISP + VFP + VPULSE);

  // hcnt_q/vcnt_q name the raster position the outputs take on at the next
  // enabled edge. Coming out of reset they therefore point at (0,0), and the
  // first enabled edge presents the frame origin.
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;

  logic        hs_d, vs_d, de_d, fs_d, ls_d;
  logic [10:0] px_d;
  logic [9:0]  py_d;
  logic        h_act_s, v_act_s;

  // Raster position advance with end-of-line and end-of-frame wrap.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 11'd0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = 10'd0;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end
  end

  // Output decode of the current position. vcnt only changes together with
  // the horizontal wrap, so vsync edges always land on a column-0 cycle.
  always_comb begin
    h_act_s = ({1'b0, hcnt_q} < H_DISP_E);
    v_act_s = ({1'b0, vcnt_q} < V_DISP_E);
    de_d    = h_act_s & v_act_s;
    hs_d    = ~(({1'b0, hcnt_q} >= H_SYNC_B) && ({1'b0, hcnt_q} < H_SYNC_E));
    vs_d    = ~(({1'b0, vcnt_q} >= V_SYNC_B) && ({1'b0, vcnt_q} < V_SYNC_E));
    if (de_d) begin
      px_d = hcnt_q;
      py_d = vcnt_q;
    end else begin
      px_d = 11'd0;
      py_d = 10'd0;
    end
    ls_d = (hcnt_q == 11'd0) && v_act_s;
    fs_d = (hcnt_q == 11'd0) && (vcnt_q == 10'd0);
  end

  // Counter and output registers; everything holds while en is low.
  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      hcnt_q      <= 11'd0;
      vcnt_q      <= 10'd0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      pix_x       <= 11'd0;
      pix_y       <= 10'd0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      vga_de      <= de_d;
      pix_x       <= px_d;
      pix_y       <= py_d;
      frame_start <= fs_d;
      line_start  <= ls_d;
    end
  end

endmodule
